// File: rtl/pong_pkg.sv
// Shared encodings, bus addresses and geometry helpers for the Pong
// game-sequencing controller.
package pong_pkg;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_PLAY = 2'd1,
        M_OVER = 2'd2
    } mode_e;

    typedef enum logic [2:0] {
        S_WAIT = 3'd0,
        S_PAD  = 3'd1,
        S_BALL = 3'd2,
        S_WR0  = 3'd3,
        S_WR1  = 3'd4,
        S_WR2  = 3'd5,
        S_WR3  = 3'd6
    } seq_e;

    localparam logic [1:0] ADDR_BALL_X = 2'd0;
    localparam logic [1:0] ADDR_BALL_Y = 2'd1;
    localparam logic [1:0] ADDR_PAD1   = 2'd2;
    localparam logic [1:0] ADDR_PAD2   = 2'd3;

    localparam int DEF_WIDTH  = 640;
    localparam int DEF_HEIGHT = 480;
    localparam int DEF_BORDER = 10;
    localparam int DEF_BALL   = 10;
    localparam int DEF_PAD_H  = 80;

    function automatic int pad_min(input int border);
        return border;
    endfunction

    function automatic int pad_max(input int height, input int border,
                                   input int pad_h);
        return height - border - pad_h;
    endfunction

    function automatic int ball_xmax(input int height, input int border,
                                     input int ball);
        return height - border - ball;
    endfunction

    function automatic int serve_x(input int height, input int ball);
        return (height - ball) / 2;
    endfunction

    function automatic int serve_y(input int width, input int ball);
        return (width - ball) / 2;
    endfunction

    function automatic int pad_init(input int height, input int pad_h);
        return (height - pad_h) / 2;
    endfunction

    localparam int PAD_MIN   = pad_min(DEF_BORDER);
    localparam int PAD_MAX   = pad_max(DEF_HEIGHT, DEF_BORDER, DEF_PAD_H);
    localparam int BALL_XMAX = ball_xmax(DEF_HEIGHT, DEF_BORDER, DEF_BALL);
    localparam int SERVE_X   = serve_x(DEF_HEIGHT, DEF_BALL);
    localparam int SERVE_Y   = serve_y(DEF_WIDTH, DEF_BALL);

endpackage

// File: rtl/pong_ctrl_paddle.sv
// Registered saturating paddle row update: one step per enabled cycle,
// opposing inputs cancel, result held inside [MIN, MAX].
module paddle_step
    import pong_pkg::*;
#(
    parameter int XB   = 8,
    parameter int STEP = 4,
    parameter int MIN  = 10,
    parameter int MAX  = 390,
    parameter int INIT = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic        i_up,
    input  logic        i_dn,
    output logic [XB:0] o_row
);

    localparam logic signed [11:0] C_STEP = 12'(STEP);
    localparam logic signed [11:0] C_MIN  = 12'(MIN);
    localparam logic signed [11:0] C_MAX  = 12'(MAX);

    logic [XB:0]        r_row;
    logic signed [11:0] w_cur;
    logic signed [11:0] w_nxt;
    logic               w_unused;

    assign w_cur    = 12'(r_row);
    assign o_row    = r_row;
    assign w_unused = ^w_nxt[11:XB+1];

    always_comb begin
        w_nxt = w_cur;
        if (i_up && !i_dn) begin
            w_nxt = w_cur - C_STEP;
        end else if (i_dn && !i_up) begin
            w_nxt = w_cur + C_STEP;
        end
        if (w_nxt < C_MIN) begin
            w_nxt = C_MIN;
        end else if (w_nxt > C_MAX) begin
            w_nxt = C_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row <= (XB+1)'(INIT);
        end else if (i_en) begin
            r_row <= w_nxt[XB:0];
        end
    end

endmodule

// File: rtl/pong_ctrl.sv
// Per-frame Pong sequencer: paddle step, ball step with bounces and
// scoring, then a four-beat register write burst to the display.
module pong_ctrl
    import pong_pkg::*;
#(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int X_BIT       = 8,
    parameter int Y_BIT       = 9,
    parameter int BORDER      = 10,
    parameter int BALL        = 10,
    parameter int PAD_H       = 80,
    parameter int PAD_W       = 10,
    parameter int PAD1_Y      = 30,
    parameter int PAD2_Y      = 600,
    parameter int PAD_STEP    = 4,
    parameter int BALL_STEP   = 2,
    parameter int SERVE_DELAY = 60,
    parameter int WIN_SCORE   = 9
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           frame_tick,
    input  logic           start,
    input  logic           p1_up,
    input  logic           p1_dn,
    input  logic           p2_up,
    input  logic           p2_dn,
    output logic           sel,
    output logic [1:0]     addr,
    output logic [Y_BIT:0] data_out,
    output logic [3:0]     score1,
    output logic [3:0]     score2,
    output logic           playing
);

    localparam int XW  = X_BIT + 1;
    localparam int YW  = Y_BIT + 1;
    localparam int SW  = $clog2(SERVE_DELAY + 1);
    localparam int SX  = serve_x(HEIGHT, BALL);
    localparam int SY  = serve_y(WIDTH, BALL);

    typedef logic signed [10:0] s11_t;

    localparam s11_t C_BORDER = s11_t'(BORDER);
    localparam s11_t C_BXMAX  = s11_t'(ball_xmax(HEIGHT, BORDER, BALL));
    localparam s11_t C_BALL   = s11_t'(BALL);
    localparam s11_t C_PADH   = s11_t'(PAD_H);
    localparam s11_t C_P1F    = s11_t'(PAD1_Y + PAD_W);
    localparam s11_t C_P2Y    = s11_t'(PAD2_Y);
    localparam s11_t C_YEDGE  = s11_t'(WIDTH - BORDER);
    localparam s11_t C_BSTEP  = s11_t'(BALL_STEP);

    mode_e          r_mode;
    seq_e           r_seq;
    logic [X_BIT:0] r_bx;
    logic [Y_BIT:0] r_by;
    logic           r_dx;
    logic           r_dy;
    logic [SW-1:0]  r_serve;
    logic [3:0]     r_s1;
    logic [3:0]     r_s2;

    logic [X_BIT:0] w_pad1;
    logic [X_BIT:0] w_pad2;
    logic           w_pad_en;

    s11_t w_x0, w_y0, w_p1, w_p2;
    s11_t w_nx, w_ny, w_cx, w_cy;
    logic w_mdx, w_mdy, w_hit1, w_hit2, w_pt1, w_pt2;

    logic [X_BIT:0] w_bx_n;
    logic [Y_BIT:0] w_by_n;
    logic           w_dx_n;
    logic           w_dy_n;
    logic [SW-1:0]  w_serve_n;
    logic [3:0]     w_s1_n;
    logic [3:0]     w_s2_n;
    mode_e          w_mode_n;
    logic           w_unused;

    assign w_pad_en = (r_seq == S_PAD) && (r_mode == M_PLAY);

    paddle_step #(
        .XB   (X_BIT),
        .STEP (PAD_STEP),
        .MIN  (pad_min(BORDER)),
        .MAX  (pad_max(HEIGHT, BORDER, PAD_H)),
        .INIT (pad_init(HEIGHT, PAD_H))
    ) u_pad1 (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_pad_en),
        .i_up  (p1_up),
        .i_dn  (p1_dn),
        .o_row (w_pad1)
    );

    paddle_step #(
        .XB   (X_BIT),
        .STEP (PAD_STEP),
        .MIN  (pad_min(BORDER)),
        .MAX  (pad_max(HEIGHT, BORDER, PAD_H)),
        .INIT (pad_init(HEIGHT, PAD_H))
    ) u_pad2 (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_pad_en),
        .i_up  (p2_up),
        .i_dn  (p2_dn),
        .o_row (w_pad2)
    );

    assign w_x0 = s11_t'(r_bx);
    assign w_y0 = s11_t'(r_by);
    assign w_p1 = s11_t'(w_pad1);
    assign w_p2 = s11_t'(w_pad2);
    assign w_nx = r_dx ? w_x0 + C_BSTEP : w_x0 - C_BSTEP;
    assign w_ny = r_dy ? w_y0 + C_BSTEP : w_y0 - C_BSTEP;
    assign w_unused = ^{w_cx[10:XW], w_cy[10:YW]};

    always_comb begin
        w_cx  = w_nx;
        w_mdx = r_dx;
        if (w_nx <= C_BORDER) begin
            w_cx  = C_BORDER;
            w_mdx = 1'b1;
        end else if (w_nx >= C_BXMAX) begin
            w_cx  = C_BXMAX;
            w_mdx = 1'b0;
        end
        w_hit1 = !r_dy && (w_y0 >= C_P1F) && (w_ny < C_P1F) &&
                 (w_cx + C_BALL > w_p1) && (w_cx < w_p1 + C_PADH);
        w_hit2 = r_dy && (w_y0 + C_BALL <= C_P2Y) &&
                 (w_ny + C_BALL > C_P2Y) &&
                 (w_cx + C_BALL > w_p2) && (w_cx < w_p2 + C_PADH);
        w_cy  = w_ny;
        w_mdy = r_dy;
        w_pt1 = 1'b0;
        w_pt2 = 1'b0;
        // Paddle faces win over the side-wall miss test.
        if (w_hit1) begin
            w_cy  = C_P1F;
            w_mdy = 1'b1;
        end else if (w_hit2) begin
            w_cy  = C_P2Y - C_BALL;
            w_mdy = 1'b0;
        end else if (w_ny <= C_BORDER) begin
            w_pt2 = 1'b1;
        end else if (w_ny + C_BALL >= C_YEDGE) begin
            w_pt1 = 1'b1;
        end
    end

    always_comb begin
        w_bx_n    = r_bx;
        w_by_n    = r_by;
        w_dx_n    = r_dx;
        w_dy_n    = r_dy;
        w_serve_n = r_serve;
        w_s1_n    = r_s1;
        w_s2_n    = r_s2;
        w_mode_n  = r_mode;
        if (r_mode == M_PLAY) begin
            if (r_serve != '0) begin
                w_serve_n = r_serve - SW'(1);
            end else begin
                w_bx_n = w_cx[X_BIT:0];
                w_by_n = w_cy[Y_BIT:0];
                w_dx_n = w_mdx;
                w_dy_n = w_mdy;
                if (w_pt1 || w_pt2) begin
                    w_bx_n    = XW'(SX);
                    w_by_n    = YW'(SY);
                    w_dy_n    = w_pt1;
                    w_serve_n = SW'(SERVE_DELAY);
                    if (w_pt1) begin
                        w_s1_n = r_s1 + 4'd1;
                    end else begin
                        w_s2_n = r_s2 + 4'd1;
                    end
                    if (w_s1_n == 4'(WIN_SCORE) ||
                        w_s2_n == 4'(WIN_SCORE)) begin
                        w_mode_n = M_OVER;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode   <= M_IDLE;
            r_seq    <= S_WAIT;
            r_bx     <= XW'(SX);
            r_by     <= YW'(SY);
            r_dx     <= 1'b1;
            r_dy     <= 1'b1;
            r_serve  <= '0;
            r_s1     <= '0;
            r_s2     <= '0;
            sel      <= 1'b0;
            addr     <= '0;
            data_out <= '0;
            score1   <= '0;
            score2   <= '0;
            playing  <= 1'b0;
        end else begin
            unique case (r_seq)
                S_WAIT: begin
                    if (start && r_mode != M_PLAY) begin
                        r_mode  <= M_PLAY;
                        r_s1    <= '0;
                        r_s2    <= '0;
                        r_bx    <= XW'(SX);
                        r_by    <= YW'(SY);
                        r_dy    <= 1'b1;
                        r_serve <= SW'(SERVE_DELAY);
                    end
                    if (frame_tick) begin
                        r_seq <= S_PAD;
                    end
                end
                S_PAD: r_seq <= S_BALL;
                S_BALL: begin
                    r_seq    <= S_WR0;
                    r_bx     <= w_bx_n;
                    r_by     <= w_by_n;
                    r_dx     <= w_dx_n;
                    r_dy     <= w_dy_n;
                    r_serve  <= w_serve_n;
                    r_s1     <= w_s1_n;
                    r_s2     <= w_s2_n;
                    r_mode   <= w_mode_n;
                    score1   <= w_s1_n;
                    score2   <= w_s2_n;
                    playing  <= (w_mode_n == M_PLAY);
                    sel      <= 1'b1;
                    addr     <= ADDR_BALL_X;
                    data_out <= YW'(w_bx_n);
                end
                S_WR0: begin
                    r_seq    <= S_WR1;
                    addr     <= ADDR_BALL_Y;
                    data_out <= r_by;
                end
                S_WR1: begin
                    r_seq    <= S_WR2;
                    addr     <= ADDR_PAD1;
                    data_out <= YW'(w_pad1);
                end
                S_WR2: begin
                    r_seq    <= S_WR3;
                    addr     <= ADDR_PAD2;
                    data_out <= YW'(w_pad2);
                end
                S_WR3: begin
                    r_seq    <= S_WAIT;
                    sel      <= 1'b0;
                    addr     <= '0;
                    data_out <= '0;
                end
                default: r_seq <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_ctrl.sv
// Frame-level bench for pong_ctrl: drives ticks and paddle inputs and
// compares every write burst with an integer game model.
module tb_pong_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       p1_up = 1'b0;
    logic       p1_dn = 1'b0;
    logic       p2_up = 1'b0;
    logic       p2_dn = 1'b0;
    logic       sel;
    logic [1:0] addr;
    logic [9:0] data_out;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       playing;

    int n_chk = 0;
    int n_err = 0;

    int m_mode, m_bx, m_by, m_dx, m_dy, m_p1, m_p2, m_serve, m_s1, m_s2;
    int last_wr[4];
    bit saw590;

    pong_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .start      (start),
        .p1_up      (p1_up),
        .p1_dn      (p1_dn),
        .p2_up      (p2_up),
        .p2_dn      (p2_dn),
        .sel        (sel),
        .addr       (addr),
        .data_out   (data_out),
        .score1     (score1),
        .score2     (score2),
        .playing    (playing)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void mdl_reset();
        m_mode = 0; m_bx = 235; m_by = 315; m_dx = 1; m_dy = 1;
        m_p1 = 200; m_p2 = 200; m_serve = 0; m_s1 = 0; m_s2 = 0;
    endfunction

    function automatic int pad_mv(input int p, input bit up, input bit dn);
        int r = p;
        if (up && !dn) r = p - 4;
        if (dn && !up) r = p + 4;
        if (r < 10) r = 10;
        if (r > 390) r = 390;
        return r;
    endfunction

    function automatic void point(input int who);
        if (who == 1) begin
            m_s1++; m_dy = 1;
        end else begin
            m_s2++; m_dy = -1;
        end
        m_bx = 235; m_by = 315; m_serve = 60;
        if (m_s1 == 9 || m_s2 == 9) m_mode = 2;
    endfunction

    function automatic void mdl_frame(input bit st, input bit a, input bit b,
                                      input bit c, input bit d);
        int nx, ny;
        if (st && m_mode != 1) begin
            m_mode = 1; m_s1 = 0; m_s2 = 0; m_dy = 1; m_serve = 60;
            m_bx = 235; m_by = 315;
        end
        if (m_mode != 1) return;
        m_p1 = pad_mv(m_p1, a, b);
        m_p2 = pad_mv(m_p2, c, d);
        if (m_serve > 0) begin
            m_serve--;
            return;
        end
        nx = m_bx + 2 * m_dx;
        ny = m_by + 2 * m_dy;
        if (nx <= 10) begin
            nx = 10; m_dx = 1;
        end else if (nx >= 460) begin
            nx = 460; m_dx = -1;
        end
        if (m_dy < 0 && m_by >= 40 && ny < 40 && nx + 10 > m_p1 && nx < m_p1 + 80) begin
            ny = 40; m_dy = 1;
        end else if (m_dy > 0 && m_by + 10 <= 600 && ny + 10 > 600 &&
                     nx + 10 > m_p2 && nx < m_p2 + 80) begin
            ny = 590; m_dy = -1;
        end
        m_bx = nx; m_by = ny;
        if (ny <= 10 && m_dy < 0 && m_by != 40) point(2);
        else if (ny + 10 >= 630) point(1);
    endfunction

    task automatic frame(input bit st, input bit a, input bit b,
                         input bit c, input bit d, input bit xtra);
        int exp_wr[4];
        @(negedge clk);
        frame_tick = 1; start = st;
        p1_up = a; p1_dn = b; p2_up = c; p2_dn = d;
        mdl_frame(st, a, b, c, d);
        exp_wr = '{m_bx, m_by, m_p1, m_p2};
        @(negedge clk);
        frame_tick = 0; start = 0;
        chk("sel_k1", sel, 0);
        @(negedge clk);
        p1_up = 0; p1_dn = 0; p2_up = 0; p2_dn = 0;
        chk("sel_k2", sel, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            frame_tick = (xtra && i == 1);
            chk("wr_sel", sel, 1);
            chk("wr_addr", addr, i);
            chk("wr_data", data_out, exp_wr[i]);
            last_wr[i] = data_out;
            if (i == 0) begin
                chk("score1", score1, m_s1);
                chk("score2", score2, m_s2);
                chk("playing", playing, m_mode == 1);
            end
            if (i == 1 && data_out == 10'd590) saw590 = 1;
        end
        @(negedge clk);
        frame_tick = 0;
        chk("sel_end", sel, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst_sel", sel, 0);
        chk("rst_addr", addr, 0);
        chk("rst_data", data_out, 0);
        chk("rst_s1", score1, 0);
        chk("rst_s2", score2, 0);
        chk("rst_play", playing, 0);
        rst = 1;
        mdl_reset();
    endtask

    initial begin
        int fr;
        bit a, b, c, d;
        mdl_reset();
        saw590 = 0;
        repeat (2) @(negedge clk);
        do_reset();

        frame(0, 0, 0, 0, 0, 0);

        frame(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 49; i++) frame(0, 1, 0, 0, 0, i[0]);
        chk("p1_min", last_wr[2], 10);
        for (int i = 0; i < 5; i++) frame(0, 1, 1, 1, 1, 1);
        chk("p1_hold", last_wr[2], 10);
        chk("p2_hold", last_wr[3], 200);

        do_reset();
        frame(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 229; i++) frame(0, 0, 0, 0, 0, $urandom_range(0, 1));
        chk("s1_miss", score1, 1);

        do_reset();
        saw590 = 0;
        frame(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 47; i++) frame(0, 0, 0, 0, 1, 0);
        chk("p2_max", last_wr[3], 390);
        for (int i = 0; i < 200; i++) frame(0, 0, 0, 0, 0, 0);
        chk("clamp590", saw590, 1);
        chk("s1_nochg", score1, 0);

        do_reset();
        frame(1, 0, 0, 0, 0, 0);
        for (fr = 0; fr < 6000 && m_mode != 2; fr++) begin
            a = (m_bx + 5 < m_p1 + 38);
            b = (m_bx + 5 > m_p1 + 42);
            c = (m_bx + 5 >= m_p2 + 40);
            d = !c;
            if ($urandom_range(0, 7) == 0) begin
                c = 1'($urandom_range(0, 1));
                d = 1'($urandom_range(0, 1));
            end
            frame(0, a, b, c, d, 1'($urandom_range(0, 1)));
        end
        chk("over_play", playing, 0);
        for (int i = 0; i < 3; i++)
            frame(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
        frame(1, 0, 0, 0, 0, 0);
        chk("restart_play", playing, 1);
        chk("restart_s1", score1, 0);

        @(negedge clk);
        frame_tick = 1;
        @(negedge clk);
        frame_tick = 0;
        repeat (3) @(negedge clk);
        chk("mid_sel", sel, 1);
        chk("mid_addr", addr, 1);
        #2 rst = 0;
        #1;
        chk("async_sel", sel, 0);
        chk("async_data", data_out, 0);
        @(negedge clk);
        rst = 1;
        mdl_reset();
        frame(0, 0, 0, 0, 0, 0);
        chk("post_bx", last_wr[0], 235);
        chk("post_p2", last_wr[3], 200);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pong_ctrl.md
# pong_ctrl

Game-sequencing controller for the arcade display path. Once per video frame it advances the Pong game state (two paddles, ball motion, wall/paddle bounces, scoring, serve pause) and then drives the four-register display write bus (`sel`/`addr`/`data`) with ball row/column and paddle rows. Coordinates: x = row (0..HEIGHT-1), y = column (0..WIDTH-1). Objects are addressed by their top-left corner.

## Interface
- WIDTH, 640, screen columns
- HEIGHT, 480, screen rows
- X_BIT, 8, MSB index of row values (rows are X_BIT+1 bits)
- Y_BIT, 9, MSB index of column values and of the data bus
- BORDER, 10, frame border thickness
- BALL, 10, ball edge length
- PAD_H, 80, paddle height in rows
- PAD_W, 10, paddle width in columns
- PAD1_Y, 30, left paddle column
- PAD2_Y, 600, right paddle column
- PAD_STEP, 4, paddle rows moved per frame
- BALL_STEP, 2, ball pixels moved per frame on each axis
- SERVE_DELAY, 60, frozen-ball frames after a serve
- WIN_SCORE, 9, score that ends the game
- clk  in  1  system clock; same clock as the display path
- rst  in  1  reset; asynchronous, active-low
- frame_tick  in  1  one-cycle pulse per frame, issued at the start of vertical blank
- start  in  1  level; starts a new game from IDLE or OVER
- p1_up, p1_dn, p2_up, p2_dn  in  1 each  paddle controls; up decreases the row
- sel  out  1  write strobe to the display
- addr  out  2  0 = ball row, 1 = ball column, 2 = paddle 1 row, 3 = paddle 2 row
- data_out  out  Y_BIT+1  write data; row values are zero-extended
- score1, score2  out  4 each  player scores
- playing  out  1  high while the mode is PLAY

## Operation
- Mode register: IDLE → PLAY (on `start`) → OVER (when a score reaches WIN_SCORE) → PLAY (on `start`). `start` clears both scores, serves with the ball moving toward player 2, and loads the serve counter. `start` is ignored while in PLAY.
- Sequencer states: WAIT → PAD → BALL → WR0 → WR1 → WR2 → WR3 → WAIT. It leaves WAIT only on `frame_tick`, and it runs in every mode.
- PAD (PLAY only):
  - Each paddle moves ±PAD_STEP. If up and down are both asserted, the paddle does not move.
  - The paddle row saturates to the range [BORDER, HEIGHT-BORDER-PAD_H], i.e. 10..390.
- BALL (PLAY only):
  - If the serve counter is nonzero, decrement it and leave the ball unchanged.
  - Otherwise compute nx = bx±BALL_STEP and ny = by±BALL_STEP in 11-bit signed arithmetic.
  - Row: nx ≤ BORDER → clamp to BORDER, dx = +. nx ≥ HEIGHT-BORDER-BALL (460) → clamp to 460, dx = −.
  - Left paddle hit requires all of the following; then ny = 40 and dy = +:
    - dy = −
    - old by ≥ PAD1_Y+PAD_W (40)
    - ny < 40
    - row overlap: nx+BALL > pad1 and nx < pad1+PAD_H
  - Right paddle hit requires all of the following; then ny = 590 and dy = −:
    - dy = +
    - old by+BALL ≤ PAD2_Y
    - ny+BALL > 600
    - row overlap with pad2
  - Miss: ny ≤ BORDER means a point for player 2; ny+BALL ≥ WIDTH-BORDER (630) means a point for player 1.
  - On a point:
    - The scorer's count increments.
    - The ball resets to (235, 315) with dy toward the player who conceded; dx is kept.
    - The serve counter is loaded with SERVE_DELAY.
    - If the new score equals WIN_SCORE, the mode becomes OVER.
  - The paddle-hit test takes priority over the wall/miss test.
- WR0..WR3: `sel` = 1, addr = 0..3, `data_out` = the matching register value.
- IDLE and OVER: positions are frozen, but the writes still occur every frame.
- `frame_tick` is ignored outside WAIT.

## Timing
- Reset values:
  - Outputs: sel = 0, addr = 0, data_out = 0, scores = 0, playing = 0.
  - Internal: mode IDLE, sequencer WAIT, ball (235, 315), paddles 200, dx = +, dy = +, serve counter 0.
- If `frame_tick` is high in cycle k, `sel` is high in cycles k+3..k+6 with addr 0,1,2,3. All outputs are registered.
- The update plus write burst completes 7 cycles after the tick, well inside vertical blank.
- Scores and `playing` update in cycle k+3, together with the first write.
- `start` is sampled only in WAIT. Paddle inputs are sampled in PAD.
- Asynchronous reset mid-burst drops `sel` immediately. Any partial burst is superseded by the next frame's full burst.

## Structure
- `pong_pkg` holds:
  - the mode and sequencer state encodings;
  - the address constants ADDR_BALL_X/Y and ADDR_PAD1/2;
  - the derived limits (PAD_MIN, PAD_MAX, BALL_XMAX, serve position).
- One sub-module, `paddle_step`, is instantiated twice. It is the registered saturating paddle update with inputs up, dn, en.

## Test plan
- Reset, then one tick → writes 235, 315, 200, 200 at addr 0..3 in cycles k+3..k+6; playing = 0.
- `start`, then hold `p1_up` for 50 ticks → paddle 1 write = 10 and never below 10. Both up and down held → value unchanged.
- `start`, SERVE_DELAY ticks of frozen ball, then free run with paddles at 200 → ball row reaches 460 and reflects. Ball misses paddle 2 and score1 = 1 on the tick where ny ≥ 620. Next burst shows the ball at 235/315.
- Same as above, but hold `p2_dn` for 48 ticks first (paddle 2 = 390) → ball column clamps to 590 with dy = −; no score change.
- Force 9 points for player 1 → mode OVER, playing = 0, positions frozen. `start` → scores 0, playing = 1.
- Assert `rst` during WR1 → sel = 0 without waiting for a clock edge. After release, the next tick gives a full reset-value burst.
